// File: rtl/ascii_bcd_counter_pkg.sv
// Shared types, ASCII constants and helpers for the ASCII BCD counter.
package ascii_counter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_EMIT  = 3'd2,
    ST_STEP  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } state_e;

  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_NINE = 8'h39;
  localparam logic [7:0] ASCII_LF   = 8'h0A;

  function automatic logic is_digit(input logic [7:0] c);
    return (c >= ASCII_ZERO) && (c <= ASCII_NINE);
  endfunction

  function automatic logic [7:0] bcd_to_ascii(input logic [3:0] d);
    return ASCII_ZERO + {4'h0, d};
  endfunction

endpackage

// File: rtl/ascii_bcd_counter_bcd_digit.sv
// One decimal digit of the counter: add or subtract an amount plus carry/borrow,
// with a synchronous load. Digits are chained LSD to MSD by the parent.
module bcd_digit (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [3:0] load_val_i,
  input  logic       en_i,
  input  logic       sub_i,
  input  logic [3:0] amt_i,
  input  logic       cin_i,
  output logic [3:0] digit_o,
  output logic [3:0] next_o,
  output logic       cout_o
);

  logic [3:0] digit_q, digit_d;
  logic [4:0] raw_s;
  logic [4:0] adj_s;

  // Decimal add/subtract with carry or borrow out of this digit.
  always_comb begin
    raw_s  = 5'd0;
    adj_s  = 5'd0;
    next_o = digit_q;
    cout_o = 1'b0;
    if (sub_i) begin
      raw_s = {1'b0, digit_q} - {1'b0, amt_i} - {4'd0, cin_i};
      adj_s = raw_s + 5'd10;
      if (raw_s[4]) begin
        next_o = adj_s[3:0];
        cout_o = 1'b1;
      end else begin
        next_o = raw_s[3:0];
        cout_o = 1'b0;
      end
    end else begin
      raw_s = {1'b0, digit_q} + {1'b0, amt_i} + {4'd0, cin_i};
      adj_s = raw_s - 5'd10;
      if (raw_s > 5'd9) begin
        next_o = adj_s[3:0];
        cout_o = 1'b1;
      end else begin
        next_o = raw_s[3:0];
        cout_o = 1'b0;
      end
    end
  end

  // Next digit value: load wins over step.
  always_comb begin
    if (load_i) begin
      digit_d = load_val_i;
    end else if (en_i) begin
      digit_d = next_o;
    end else begin
      digit_d = digit_q;
    end
  end

  // Digit register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      digit_q <= 4'd0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/ascii_bcd_counter.sv
// ASCII decimal up/down counter streaming each value over a valid/ready byte port.
// Define ASCII_COUNTER_SEP_EN to append an LF after every emitted value.
module ascii_bcd_counter
  import ascii_counter_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int STEP   = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [8*DIGITS-1:0]   value,
  input  logic                  mode_up,
  input  logic                  start,
  output logic [7:0]            ascii_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  done,
  output logic                  error
);

  localparam int         IDXW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int         MSD      = DIGITS - 1;
  localparam logic [3:0] STEP_AMT = 4'(STEP);

  state_e                state_q, state_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [4*DIGITS-1:0]   limit_q, limit_d;
  logic                  mode_q, mode_d;
  logic [IDXW-1:0]       idx_q, idx_d;
  logic [7:0]            ascii_q, ascii_d;
  logic                  valid_q, valid_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
`ifdef ASCII_COUNTER_SEP_EN
  logic                  sep_q, sep_d;
`endif

  logic [4*DIGITS-1:0]   value_bcd_s;
  logic                  value_ok_s;
  logic [4*DIGITS-1:0]   load_bcd_s;
  logic [4*DIGITS-1:0]   cnt_s;
  logic [4*DIGITS-1:0]   next_s;
  logic                  msd_carry_s;
  logic                  load_s;
  logic                  en_s;
  logic                  last_s;
  logic [IDXW-1:0]       idx_dec_s;

  // ASCII-to-BCD conversion and digit validation of the start value.
  always_comb begin
    value_bcd_s = '0;
    value_ok_s  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      value_bcd_s[4*i +: 4] = value[8*i +: 4];
      value_ok_s            = value_ok_s & is_digit(value[8*i +: 8]);
    end
  end

  assign load_bcd_s = mode_q ? '0 : bcd_q;

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic cin_s;
    logic cout_s;
    if (g == 0) begin : g_lsd
      assign cin_s = 1'b0;
    end else begin : g_upper
      assign cin_s = g_digit[g-1].cout_s;
    end
    bcd_digit u_digit (
      .clk_i      (clock),
      .rst_ni     (reset),
      .load_i     (load_s),
      .load_val_i (load_bcd_s[4*g +: 4]),
      .en_i       (en_s),
      .sub_i      (~mode_q),
      .amt_i      ((g == 0) ? STEP_AMT : 4'd0),
      .cin_i      (cin_s),
      .digit_o    (cnt_s[4*g +: 4]),
      .next_o     (next_s[4*g +: 4]),
      .cout_o     (cout_s)
    );
  end

  assign msd_carry_s = g_digit[DIGITS-1].cout_s;
  // A borrow out of the MSD means counter < STEP; in up mode overflow or passing the limit ends it.
  assign last_s      = mode_q ? (msd_carry_s || (next_s > limit_q)) : msd_carry_s;
  assign idx_dec_s   = idx_q - {{(IDXW-1){1'b0}}, 1'b1};

  // Control FSM next state and registered-output next values.
  always_comb begin
    state_d = state_q;
    bcd_d   = bcd_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    ascii_d = ascii_q;
    valid_d = valid_q;
    done_d  = done_q;
    error_d = error_q;
    load_s  = 1'b0;
    en_s    = 1'b0;
`ifdef ASCII_COUNTER_SEP_EN
    sep_d   = sep_q;
`endif
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d = ST_CHECK;
          bcd_d   = value_bcd_s;
          mode_d  = mode_up;
          error_d = ~value_ok_s;
          done_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_CHECK: begin
        if (error_q) begin
          state_d = ST_ERR;
        end else begin
          state_d = ST_EMIT;
          load_s  = 1'b1;
          limit_d = bcd_q;
          idx_d   = IDXW'(MSD);
          ascii_d = bcd_to_ascii(load_bcd_s[4*MSD +: 4]);
          valid_d = 1'b1;
        end
      end
      ST_EMIT: begin
        if (valid_q && out_ready) begin
          if (idx_q != '0) begin
            idx_d   = idx_dec_s;
            ascii_d = bcd_to_ascii(cnt_s[4*idx_dec_s +: 4]);
          end else begin
`ifdef ASCII_COUNTER_SEP_EN
            if (!sep_q) begin
              sep_d   = 1'b1;
              ascii_d = ASCII_LF;
            end else begin
              sep_d   = 1'b0;
              valid_d = 1'b0;
              done_d  = last_s;
              state_d = ST_STEP;
            end
`else
            valid_d = 1'b0;
            done_d  = last_s;
            state_d = ST_STEP;
`endif
          end
        end else begin
          state_d = ST_EMIT;
        end
      end
      ST_STEP: begin
        if (done_q) begin
          state_d = ST_DONE;
        end else begin
          en_s    = 1'b1;
          idx_d   = IDXW'(MSD);
          ascii_d = bcd_to_ascii(next_s[4*MSD +: 4]);
          valid_d = 1'b1;
          state_d = ST_EMIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bcd_q   <= '0;
      limit_q <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      ascii_q <= 8'h00;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
`ifdef ASCII_COUNTER_SEP_EN
      sep_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      bcd_q   <= bcd_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      ascii_q <= ascii_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      error_q <= error_d;
`ifdef ASCII_COUNTER_SEP_EN
      sep_q   <= sep_d;
`endif
    end
  end

  assign ascii_out = ascii_q;
  assign out_valid = valid_q;
  assign done      = done_q;
  assign error     = error_q;

endmodule

// File: tb/tb_ascii_bcd_counter.sv
// Directed bench for ascii_bcd_counter (2-digit STEP=1 and 3-digit STEP=5 instances).
module tb_ascii_bcd_counter;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        mode_up = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  ascii_out;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic        done;
  logic        error;

  logic [23:0] value3 = 24'h000000;
  logic        mode3 = 1'b0;
  logic        start3 = 1'b0;
  logic [7:0]  ascii3;
  logic        valid3;
  logic        ready3 = 1'b1;
  logic        done3;
  logic        error3;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  always #5 clock = ~clock;

  ascii_bcd_counter #(.DIGITS(2), .STEP(1)) dut (
    .clock(clock), .reset(reset), .value(value), .mode_up(mode_up), .start(start),
    .ascii_out(ascii_out), .out_valid(out_valid), .out_ready(out_ready),
    .done(done), .error(error)
  );

  ascii_bcd_counter #(.DIGITS(3), .STEP(5)) dut3 (
    .clock(clock), .reset(reset), .value(value3), .mode_up(mode3), .start(start3),
    .ascii_out(ascii3), .out_valid(valid3), .out_ready(ready3),
    .done(done3), .error(error3)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push_val(input int v);
    exp_q.push_back(8'h30 + 8'(v / 10));
    exp_q.push_back(8'h30 + 8'(v % 10));
`ifdef ASCII_COUNTER_SEP_EN
    exp_q.push_back(8'h0A);
`endif
  endtask

  // Pulse start for one cycle; returns at the negedge of the cycle after start.
  task automatic do_start(input logic [15:0] v, input logic m, input logic exp_err);
    @(negedge clock);
    value = v; mode_up = m; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    chk("start_valid_low", {31'd0, out_valid}, 32'd0);
    chk("start_done_clr", {31'd0, done}, 32'd0);
    chk("start_error", {31'd0, error}, {31'd0, exp_err});
  endtask

  // Collect accepted bytes; optional random ready and an injected start after inj_at bytes.
  task automatic run_stream(input string tag, input bit rand_rdy, input int inj_at);
    int         cyc = 0;
    bit         prev_stall = 1'b0;
    bit         injected = 1'b0;
    logic [7:0] prev_char = 8'h00;
    got_q.delete();
    while (got_q.size() < exp_q.size() && cyc < 1000) begin
      if (prev_stall) begin
        chk({tag, "_stall_valid"}, {31'd0, out_valid}, 32'd1);
        chk({tag, "_stall_hold"}, {24'd0, ascii_out}, {24'd0, prev_char});
      end
      out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
      if (!injected && inj_at >= 0 && got_q.size() == inj_at) begin
        start = 1'b1; value = 16'h3939; mode_up = 1'b0; injected = 1'b1;
      end else begin
        start = 1'b0;
      end
      if (out_valid && out_ready) got_q.push_back(ascii_out);
      prev_stall = out_valid && !out_ready;
      prev_char  = ascii_out;
      @(negedge clock);
      cyc++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    chk({tag, "_len"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      chk($sformatf("%s_byte%0d", tag, i),
          (i < got_q.size()) ? {24'd0, got_q[i]} : 32'hFFFF_FFFF, {24'd0, exp_q[i]});
    end
    chk({tag, "_done"}, {31'd0, done}, 32'd1);
    chk({tag, "_valid_after"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    int c;
    int n_valid;
    logic [7:0] got3[$];
    logic [7:0] exp3[$];
    int vals3[3] = '{12, 7, 2};

    #12;
    chk("rst_ascii", {24'd0, ascii_out}, 32'd0);
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    // "20" down, no stall, with first-character latency
    exp_q.delete();
    for (int v = 20; v >= 0; v--) push_val(v);
    do_start(16'h3230, 1'b0, 1'b0);
    @(negedge clock);
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("lat_char", {24'd0, ascii_out}, 32'h32);
    run_stream("down20", 1'b0, -1);

    // "03" up with an ignored start mid-stream
    exp_q.delete();
    for (int v = 0; v <= 3; v++) push_val(v);
    do_start(16'h3033, 1'b1, 1'b0);
    run_stream("up03", 1'b0, 2);

    // "2A" error, then "05" down clears it
    do_start(16'h3241, 1'b0, 1'b1);
    n_valid = 0;
    for (int i = 0; i < 5; i++) begin
      if (out_valid) n_valid++;
      @(negedge clock);
    end
    chk("err_no_valid", n_valid, 0);
    chk("err_hold", {31'd0, error}, 32'd1);
    exp_q.delete();
    for (int v = 5; v >= 0; v--) push_val(v);
    do_start(16'h3035, 1'b0, 1'b0);
    run_stream("down05", 1'b0, -1);

    // Backpressure: same sequence as the no-stall "20" run
    exp_q.delete();
    for (int v = 20; v >= 0; v--) push_val(v);
    do_start(16'h3230, 1'b0, 1'b0);
    run_stream("bp20", 1'b1, -1);

    // Zero start value in both modes
    exp_q.delete();
    push_val(0);
    do_start(16'h3030, 1'b1, 1'b0);
    run_stream("up00", 1'b0, -1);
    do_start(16'h3030, 1'b0, 1'b0);
    run_stream("down00", 1'b0, -1);

    // Single digit "01" down: checks LF placement when the separator is built in
    exp_q.delete();
    push_val(1);
    push_val(0);
    do_start(16'h3031, 1'b0, 1'b0);
    run_stream("down01", 1'b0, -1);

    // Three digits, STEP=5: "012" -> "012","007","002"
    foreach (vals3[k]) begin
      exp3.push_back(8'h30 + 8'(vals3[k] / 100));
      exp3.push_back(8'h30 + 8'((vals3[k] / 10) % 10));
      exp3.push_back(8'h30 + 8'(vals3[k] % 10));
`ifdef ASCII_COUNTER_SEP_EN
      exp3.push_back(8'h0A);
`endif
    end
    @(negedge clock);
    value3 = 24'h303132; mode3 = 1'b0; start3 = 1'b1;
    @(negedge clock);
    start3 = 1'b0;
    c = 0;
    while (got3.size() < exp3.size() && c < 300) begin
      if (valid3) got3.push_back(ascii3);
      @(negedge clock);
      c++;
    end
    chk("d3_len", got3.size(), exp3.size());
    for (int i = 0; i < exp3.size(); i++) begin
      chk($sformatf("d3_byte%0d", i),
          (i < got3.size()) ? {24'd0, got3[i]} : 32'hFFFF_FFFF, {24'd0, exp3[i]});
    end
    chk("d3_done", {31'd0, done3}, 32'd1);
    chk("d3_valid_after", {31'd0, valid3}, 32'd0);

    // Reset in the middle of the stream
    exp_q.delete();
    for (int v = 20; v >= 0; v--) push_val(v);
    do_start(16'h3230, 1'b0, 1'b0);
    got_q.delete();
    c = 0;
    while (got_q.size() < 3 && c < 100) begin
      if (out_valid) got_q.push_back(ascii_out);
      @(negedge clock);
      c++;
    end
    c = 0;
    while (!out_valid && c < 10) begin
      @(negedge clock);
      c++;
    end
    chk("mid_valid", {31'd0, out_valid}, 32'd1);
    chk("mid_char", {24'd0, ascii_out}, {24'd0, exp_q[3]});
    #1 reset = 1'b0;
    #1;
    chk("mrst_ascii", {24'd0, ascii_out}, 32'd0);
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_error", {31'd0, error}, 32'd0);
    @(negedge clock);
    reset = 1'b1;
    n_valid = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clock);
      if (out_valid) n_valid++;
    end
    chk("post_rst_quiet", n_valid, 0);
    chk("post_rst_done", {31'd0, done}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
